thread_issue_queue: RTL and testbench

- Per-thread instruction/request buffering stage that sits directly upstream of rr_arbiter.
- Holds one small FIFO per thread and drives the arbiter's req_bitmap and update_en inputs.
- Consumes the arbiter's one-hot grant to pop the selected FIFO into a registered issue output with a valid/ready handshake.
- Supports per-thread flush, for rollback.

---
 rtl/thread_issue_queue.sv | 139 +++++++++++++
 tb/tb_thread_issue_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_issue_queue.sv
// rtl/thread_issue_queue.sv - per-thread request FIFOs feeding a round-robin arbiter, with a registered issue output
//
// Purpose: buffers requests per thread, presents non-empty (and not flushed)
// threads to the arbiter, and pops the granted thread into a valid/ready
// output register. Threads can be flushed individually for rollback.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enq_valid_i/thread_i/data_i enqueue request, target thread, payload
//   thread_full_o               per-thread FIFO full flags
//   flush_bitmap_i              per-thread flush, applied at the next edge
//   req_bitmap_o, update_en_o   arbiter request vector and priority update enable
//   grant_oh_i                  one-hot arbiter grant, same cycle
//   issue_valid_o/thread_o/data_o, issue_ready_i   registered issue handshake
module thread_issue_queue #(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enq_valid_i,
  input  logic [$clog2(NUM_THREADS)-1:0] enq_thread_i,
  input  logic [DATA_WIDTH-1:0]          enq_data_i,
  output logic [NUM_THREADS-1:0]         thread_full_o,
  input  logic [NUM_THREADS-1:0]         flush_bitmap_i,
  output logic [NUM_THREADS-1:0]         req_bitmap_o,
  output logic                           update_en_o,
  input  logic [NUM_THREADS-1:0]         grant_oh_i,
  output logic                           issue_valid_o,
  output logic [$clog2(NUM_THREADS)-1:0] issue_thread_o,
  output logic [DATA_WIDTH-1:0]          issue_data_o,
  input  logic                           issue_ready_i
);

  localparam int TW = $clog2(NUM_THREADS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem    [NUM_THREADS][FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr [NUM_THREADS];
  logic [PW-1:0]         wr_ptr [NUM_THREADS];
  logic [CW-1:0]         count  [NUM_THREADS];

  logic                   can_issue;
  logic                   enq_ok;
  logic [NUM_THREADS-1:0] push_vec;
  logic [NUM_THREADS-1:0] pop_vec;
  logic                   pop_any;
  logic [TW-1:0]          pop_thread;
  logic [DATA_WIDTH-1:0]  pop_data;

  always_comb begin
    thread_full_o = '0;
    req_bitmap_o  = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      thread_full_o[t] = (count[t] == CW'(FIFO_DEPTH));
      req_bitmap_o[t]  = (count[t] != '0) & ~flush_bitmap_i[t];
    end
  end

  // The output register can take a new entry when empty or being drained.
  assign can_issue   = ~issue_valid_o | issue_ready_i;
  assign update_en_o = can_issue & (|req_bitmap_o);

  // Fullness is judged at the start of the cycle, so a same-cycle pop does
  // not make room for an enqueue to a full FIFO.
  assign enq_ok = enq_valid_i & ~thread_full_o[enq_thread_i] & ~flush_bitmap_i[enq_thread_i];

  always_comb begin
    push_vec = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      push_vec[t] = enq_ok && (enq_thread_i == TW'(t));
    end
  end

  // Masking with req_bitmap_o drops grants to empty or flushed threads.
  assign pop_vec = can_issue ? (grant_oh_i & req_bitmap_o) : '0;
  assign pop_any = |pop_vec;

  always_comb begin
    pop_thread = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (pop_vec[t]) pop_thread = TW'(t);
    end
  end

  assign pop_data = mem[pop_thread][rd_ptr[pop_thread]];

  // Payload storage needs no reset; counts decide what is valid.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (push_vec[t]) mem[t][wr_ptr[t]] <= enq_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        rd_ptr[t] <= '0;
        wr_ptr[t] <= '0;
        count[t]  <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (flush_bitmap_i[t]) begin
          rd_ptr[t] <= '0;
          wr_ptr[t] <= '0;
          count[t]  <= '0;
        end else begin
          if (push_vec[t]) wr_ptr[t] <= wr_ptr[t] + PW'(1);
          if (pop_vec[t])  rd_ptr[t] <= rd_ptr[t] + PW'(1);
          if (push_vec[t] && !pop_vec[t])      count[t] <= count[t] + CW'(1);
          else if (pop_vec[t] && !push_vec[t]) count[t] <= count[t] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_o  <= 1'b0;
      issue_thread_o <= '0;
      issue_data_o   <= '0;
    end else if (can_issue) begin
      if (pop_any) begin
        issue_valid_o  <= 1'b1;
        issue_thread_o <= pop_thread;
        issue_data_o   <= pop_data;
      end else begin
        issue_valid_o  <= 1'b0;
      end
    end else if (flush_bitmap_i[issue_thread_o]) begin
      // A stalled entry of a flushed thread is withdrawn after this cycle.
      issue_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_thread_issue_queue.sv
// tb/tb_thread_issue_queue.sv - scoreboard bench for thread_issue_queue with a behavioural round-robin arbiter
module tb_thread_issue_queue;

  localparam int NT = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          enq_valid;
  logic [1:0]    enq_thread;
  logic [DW-1:0] enq_data;
  logic [NT-1:0] thread_full;
  logic [NT-1:0] flush_bitmap;
  logic [NT-1:0] req_bitmap;
  logic          update_en;
  logic [NT-1:0] grant_oh;
  logic          issue_valid;
  logic [1:0]    issue_thread;
  logic [DW-1:0] issue_data;
  logic          issue_ready;

  thread_issue_queue #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enq_valid_i   (enq_valid),
    .enq_thread_i  (enq_thread),
    .enq_data_i    (enq_data),
    .thread_full_o (thread_full),
    .flush_bitmap_i(flush_bitmap),
    .req_bitmap_o  (req_bitmap),
    .update_en_o   (update_en),
    .grant_oh_i    (grant_oh),
    .issue_valid_o (issue_valid),
    .issue_thread_o(issue_thread),
    .issue_data_o  (issue_data),
    .issue_ready_i (issue_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter: search starts at prio_idx, moves past the winner on update.
  logic [1:0] prio_idx;
  logic [1:0] gidx;
  always_comb begin
    grant_oh = '0;
    gidx     = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (req_bitmap[(int'(prio_idx) + i) % NT]) begin
        grant_oh = NT'(1) << ((int'(prio_idx) + i) % NT);
        gidx     = 2'((int'(prio_idx) + i) % NT);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_idx <= '0;
    else if (update_en && grant_oh != '0) prio_idx <= gidx + 2'd1;
  end

  typedef struct {
    logic [1:0]    t;
    logic [DW-1:0] d;
  } exp_t;
  exp_t expq[$];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic expect_issue(input logic [1:0] t, input logic [DW-1:0] d);
    exp_t e;
    e.t = t;
    e.d = d;
    expq.push_back(e);
  endtask

  // Monitor: every completed transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && issue_valid && issue_ready) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL issue_unexpected: got thread %0d data %0h, required no transfer", issue_thread, issue_data);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("issue_thread", 64'(issue_thread), 64'(e.t));
        check("issue_data", 64'(issue_data), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [1:0] t, input logic [DW-1:0] d);
    enq_valid  = 1'b1;
    enq_thread = t;
    enq_data   = d;
  endtask

  // Park a thread-0 entry in the output, fill thread 1 past full, then drain.
  task automatic full_round(input logic [DW-1:0] park, input logic [DW-1:0] first);
    issue_ready = 1'b0;
    drive_enq(2'd0, park);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_enq(2'd1, first + DW'(i));
      tick();
      check("full_fill", 64'(thread_full), (i >= 3) ? 64'h2 : 64'h0);
    end
    enq_valid = 1'b0;
    check("full_req", 64'(req_bitmap), 64'h2);
    check("full_park", 64'(issue_thread), 64'h0);
    expect_issue(2'd0, park);
    for (int i = 0; i < 4; i++) expect_issue(2'd1, first + DW'(i));
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_thread", 64'(issue_thread), 64'h1);
      check("drain_data", 64'(issue_data), 64'(first + DW'(k)));
    end
    tick();
    check("drain_done_valid", 64'(issue_valid), 64'h0);
    check("drain_done_full", 64'(thread_full), 64'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    enq_valid    = 1'b0;
    enq_thread   = '0;
    enq_data     = '0;
    flush_bitmap = '0;
    issue_ready  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_full", 64'(thread_full), 64'h0);
    check("rst_req", 64'(req_bitmap), 64'h0);
    check("rst_update_en", 64'(update_en), 64'h0);
    check("rst_issue_valid", 64'(issue_valid), 64'h0);

    // Single entry, two-cycle latency.
    issue_ready = 1'b1;
    drive_enq(2'd2, 32'hA0);
    expect_issue(2'd2, 32'hA0);
    tick();
    enq_valid = 1'b0;
    check("single_req", 64'(req_bitmap), 64'h4);
    check("single_update_en", 64'(update_en), 64'h1);
    check("single_early_valid", 64'(issue_valid), 64'h0);
    tick();
    check("single_valid", 64'(issue_valid), 64'h1);
    check("single_thread", 64'(issue_thread), 64'h2);
    check("single_data", 64'(issue_data), 64'hA0);
    check("single_req_empty", 64'(req_bitmap), 64'h0);
    tick();
    check("single_valid_off", 64'(issue_valid), 64'h0);

    // Mid-operation reset returns arbiter priority to thread 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Round robin over one entry per thread.
    issue_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive_enq(2'(t), 32'h10 + DW'(t));
      expect_issue(2'(t), 32'h10 + DW'(t));
      tick();
    end
    enq_valid = 1'b0;
    check("rr_req", 64'(req_bitmap), 64'hE);
    check("rr_hold_thread", 64'(issue_thread), 64'h0);
    check("rr_update_en", 64'(update_en), 64'h0);
    issue_ready = 1'b1;
    for (int t = 1; t < 4; t++) begin
      tick();
      check("rr_thread", 64'(issue_thread), 64'(t));
      check("rr_valid", 64'(issue_valid), 64'h1);
    end
    tick();
    check("rr_valid_off", 64'(issue_valid), 64'h0);

    // Backpressure with threads 1 and 2 pending.
    issue_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      drive_enq(2'(t), 32'h20 + DW'(t));
      expect_issue(2'(t), 32'h20 + DW'(t));
      tick();
    end
    enq_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", 64'(issue_valid), 64'h1);
      check("bp_thread", 64'(issue_thread), 64'h0);
      check("bp_data", 64'(issue_data), 64'h20);
      check("bp_update_en", 64'(update_en), 64'h0);
      check("bp_req", 64'(req_bitmap), 64'h6);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    check("bp_next_thread1", 64'(issue_thread), 64'h1);
    tick();
    check("bp_next_thread2", 64'(issue_thread), 64'h2);
    tick();
    check("bp_valid_off", 64'(issue_valid), 64'h0);

    // Full, drop and pointer wrap, twice.
    full_round(32'h30, 32'h1);
    full_round(32'h31, 32'h6);

    // Flush of the thread held in the output, with a colliding enqueue.
    issue_ready = 1'b0;
    drive_enq(2'd3, 32'h40);
    tick();
    drive_enq(2'd3, 32'h41);
    tick();
    drive_enq(2'd3, 32'h42);
    tick();
    enq_valid = 1'b0;
    check("fl_pre_thread", 64'(issue_thread), 64'h3);
    check("fl_pre_req", 64'(req_bitmap), 64'h8);
    flush_bitmap = 4'b1000;
    drive_enq(2'd3, 32'h43);
    #1;
    check("fl_req_masked", 64'(req_bitmap), 64'h0);
    check("fl_still_presented", 64'(issue_valid), 64'h1);
    tick();
    flush_bitmap = '0;
    enq_valid    = 1'b0;
    #1;
    check("fl_valid_off", 64'(issue_valid), 64'h0);
    check("fl_req", 64'(req_bitmap), 64'h0);
    tick();
    check("fl_enq_dropped", 64'(req_bitmap), 64'h0);
    issue_ready = 1'b1;
    repeat (3) tick();
    check("fl_idle_valid", 64'(issue_valid), 64'h0);
    check("scoreboard_empty", 64'(expq.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
